// File: rtl/div_unit.sv
// 32-bit signed restoring divider: one quotient bit per clock.
// Results follow truncating division (remainder takes the dividend sign).
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        divInit,
  input  logic [31:0] value_A,
  input  logic [31:0] value_B,
  output logic [31:0] hi,
  output logic [31:0] low,
  output logic        busy,
  output logic        divStop,
  output logic        divZero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t      state;
  logic [63:0] rq;
  logic [31:0] b_mag;
  logic        sign_a;
  logic        sign_q;
  logic [5:0]  cnt;

  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] trial;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  assign a_abs = value_A[31] ? -value_A : value_A;
  assign b_abs = value_B[31] ? -value_B : value_B;
  // Partial remainder after the left shift, minus the divisor, in 33 bits.
  assign trial = rq[63:31] - {1'b0, b_mag};
  assign q_mag = rq[31:0];
  assign r_mag = rq[63:32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rq      <= '0;
      b_mag   <= '0;
      sign_a  <= 1'b0;
      sign_q  <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      low     <= '0;
      busy    <= 1'b0;
      divStop <= 1'b0;
      divZero <= 1'b0;
    end else begin
      divStop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (divInit) begin
            rq      <= {32'd0, a_abs};
            b_mag   <= b_abs;
            sign_a  <= value_A[31];
            sign_q  <= value_A[31] ^ value_B[31];
            cnt     <= '0;
            busy    <= 1'b1;
            divZero <= (value_B == 32'd0);
            state   <= (value_B == 32'd0) ? FIX : RUN;
          end
        end
        RUN: begin
          if (!trial[32]) begin
            rq <= {trial[31:0], rq[30:0], 1'b1};
          end else begin
            rq <= {rq[62:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (!divZero) begin
            low <= sign_q ? -q_mag : q_mag;
            hi  <= sign_a ? -r_mag : r_mag;
          end
          divStop <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 divInit  input  1  start request, sampled at rising edge, honoured only in IDLE.
REQ-006 value_A  input  32  dividend, two's complement, sampled with divInit.
REQ-007 value_B  input  32  divisor, two's complement, sampled with divInit.
REQ-008 hi  output  32  remainder of last completed division, registered.
REQ-009 low  output  32  quotient of last completed division, registered.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 divStop  output  1  one-cycle completion pulse.
REQ-012 divZero  output  1  divide-by-zero flag for the last request, held until next accepted divInit.

Function
REQ-013 The block SHALL implement states IDLE, RUN, FIX.
REQ-014 IDLE with divInit=1 at edge E0: latch |value_A|, |value_B|, both sign bits, clear divZero, clear 6-bit counter, set busy.
REQ-015 At E0, if value_B==0: set divZero, go to FIX; otherwise go to RUN.
REQ-016 RUN: each edge performs one restoring step on a 64-bit {R,Q} register: shift left 1, trial R-|B| in 33 bits, if non-negative keep the difference and set Q[0]=1, else restore; increment the counter.
REQ-017 RUN SHALL perform exactly 32 steps (E1..E32); at E32, go to FIX.
REQ-018 FIX at E33 (or E1 for divide-by-zero): write hi/low, assert divStop for exactly one cycle, clear busy, go to IDLE.
REQ-019 Sign rule: low = quotient magnitude, negated if the operand signs differ; hi = remainder magnitude, negated if the dividend was negative (truncating division, MIPS DIV semantics).
REQ-020 Divide-by-zero: hi and low SHALL keep their previous values; only divZero and divStop change.
REQ-021 Overflow case 0x80000000 / 0xFFFFFFFF SHALL yield low=0x80000000, hi=0, with no flag.
REQ-022 Latency: divStop high in the cycle after E33, i.e. 34 edges after the accepting edge; divide-by-zero takes 2 edges.
REQ-023 divInit while busy=1 SHALL be ignored with no effect on the operation in progress.
REQ-024 divInit during the divStop cycle SHALL be accepted, because the state is already IDLE.
REQ-025 Operands SHALL be taken only at E0; changes on value_A/value_B afterwards SHALL have no effect.
REQ-026 hi and low SHALL change only at the FIX edge, never mid-operation.

Reset
REQ-027 reset=1 SHALL immediately, without a clock edge, force: state IDLE, hi=0, low=0, busy=0, divStop=0, divZero=0, counter=0, internal registers=0.
REQ-028 Reset asserted mid-RUN SHALL abort the division with no divStop pulse; the first divInit after release starts a fresh operation.

Verification
REQ-029 value_A=100, value_B=7, divInit pulse -> after 34 edges divStop=1, low=14, hi=2, divZero=0.
REQ-030 value_A=-100 (0xFFFFFF9C), value_B=7 -> low=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); also 100/-7 -> low=-14, hi=2.
REQ-031 Prior result low=14, hi=2; then 5/0 -> divStop one cycle after acceptance, divZero=1, hi=2 and low=14 unchanged.
REQ-032 0x80000000 / 0xFFFFFFFF -> low=0x80000000, hi=0; 0/5 -> low=0, hi=0.
REQ-033 Start 100/7, assert reset at edge E10 -> busy=0, hi=low=0 immediately, no divStop; second divInit pulse at edge E5 of a run -> ignored, result unaffected.
REQ-034 Back-to-back: divInit held high through the divStop cycle -> second division accepted, its divStop 34 edges later.
